// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output path.
// Holds frame geometry, the packed complex word, bit reversal and FSM states.
package fft_pkg;

    localparam int FFT_POINTS     = 32;
    localparam int FFT_INDEX_BITS = 5;
    localparam int FFT_DATA_BITS  = 20;

    typedef struct packed {
        logic [FFT_DATA_BITS/2-1:0] re;
        logic [FFT_DATA_BITS/2-1:0] im;
    } cplx_t;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    function automatic logic [4:0] bitrev5(input logic [4:0] i);
        return {i[0], i[1], i[2], i[3], i[4]};
    endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// Single-frame register file with parallel load and a registered read port.
// A load forwards the incoming word so beat 0 is ready on the next cycle.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int p_dataBits  = 20,
    parameter int p_points    = FFT_POINTS,
    parameter int p_indexBits = FFT_INDEX_BITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load,
    input  logic [p_points-1:0][p_dataBits-1:0] din,
    input  logic [p_indexBits-1:0]              rd_idx,
    output logic [p_dataBits-1:0]               rd_word
);

    logic [p_points-1:0][p_dataBits-1:0] mem;

    // Frame storage: captured in one shot when a frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (load) begin
            mem <= din;
        end
    end

    // Read register tracks the word for the upcoming beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word <= '0;
        end else if (load) begin
            rd_word <= din[rd_idx];
        end else begin
            rd_word <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/fft_frame_serializer.sv
// Streams one 32-point parallel FFT frame out one word per valid/ready beat.
// Define FFT_SERIALIZER_BITREV_EN to read the buffer in bit-reversed order.
module fft_frame_serializer
    import fft_pkg::*;
#(
    parameter int p_dataBits  = 20,
    parameter int p_points    = 32,
    parameter int p_indexBits = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   i_frame_valid,
    input  logic [p_dataBits-1:0]  i_c0,
    input  logic [p_dataBits-1:0]  i_c1,
    input  logic [p_dataBits-1:0]  i_c2,
    input  logic [p_dataBits-1:0]  i_c3,
    input  logic [p_dataBits-1:0]  i_c4,
    input  logic [p_dataBits-1:0]  i_c5,
    input  logic [p_dataBits-1:0]  i_c6,
    input  logic [p_dataBits-1:0]  i_c7,
    input  logic [p_dataBits-1:0]  i_c8,
    input  logic [p_dataBits-1:0]  i_c9,
    input  logic [p_dataBits-1:0]  i_c10,
    input  logic [p_dataBits-1:0]  i_c11,
    input  logic [p_dataBits-1:0]  i_c12,
    input  logic [p_dataBits-1:0]  i_c13,
    input  logic [p_dataBits-1:0]  i_c14,
    input  logic [p_dataBits-1:0]  i_c15,
    input  logic [p_dataBits-1:0]  i_c16,
    input  logic [p_dataBits-1:0]  i_c17,
    input  logic [p_dataBits-1:0]  i_c18,
    input  logic [p_dataBits-1:0]  i_c19,
    input  logic [p_dataBits-1:0]  i_c20,
    input  logic [p_dataBits-1:0]  i_c21,
    input  logic [p_dataBits-1:0]  i_c22,
    input  logic [p_dataBits-1:0]  i_c23,
    input  logic [p_dataBits-1:0]  i_c24,
    input  logic [p_dataBits-1:0]  i_c25,
    input  logic [p_dataBits-1:0]  i_c26,
    input  logic [p_dataBits-1:0]  i_c27,
    input  logic [p_dataBits-1:0]  i_c28,
    input  logic [p_dataBits-1:0]  i_c29,
    input  logic [p_dataBits-1:0]  i_c30,
    input  logic [p_dataBits-1:0]  i_c31,
    output logic                   o_frame_ready,
    output logic [p_dataBits-1:0]  o_data,
    output logic [p_indexBits-1:0] o_index,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_overrun
);

    if (p_points != FFT_POINTS || p_indexBits != FFT_INDEX_BITS) begin : g_bad_points
        $fatal(1, "fft_frame_serializer: p_points must be 32");
    end
    if (p_dataBits % 2 != 0) begin : g_bad_width
        $fatal(1, "fft_frame_serializer: p_dataBits must be even");
    end

    localparam logic [p_indexBits-1:0] LastIdx = p_indexBits'(p_points - 1);

    logic [p_points-1:0][p_dataBits-1:0] frame;
    state_t                              state, state_nxt;
    logic [p_indexBits-1:0]              cnt, cnt_nxt, rd_idx;
    logic                                ovr_nxt;
    logic                                load;

    assign frame = {
        i_c31, i_c30, i_c29, i_c28, i_c27, i_c26, i_c25, i_c24,
        i_c23, i_c22, i_c21, i_c20, i_c19, i_c18, i_c17, i_c16,
        i_c15, i_c14, i_c13, i_c12, i_c11, i_c10, i_c9,  i_c8,
        i_c7,  i_c6,  i_c5,  i_c4,  i_c3,  i_c2,  i_c1,  i_c0
    };

    assign o_valid       = (state == STREAM);
    assign o_busy        = (state == STREAM);
    assign o_last        = (state == STREAM) && (cnt == LastIdx);
    assign o_index       = cnt;
    assign o_frame_ready = (state == IDLE) || (o_last && i_ready);
    assign load          = i_frame_valid && o_frame_ready;

`ifdef FFT_SERIALIZER_BITREV_EN
    assign rd_idx = bitrev5(cnt_nxt);
`else
    assign rd_idx = cnt_nxt;
`endif

    // State, beat counter and sticky overrun flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            o_overrun <= ovr_nxt;
        end
    end

    // Next state: a new frame wins over end-of-frame so there is no bubble.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ovr_nxt   = o_overrun || (i_frame_valid && !o_frame_ready);
        if (load) begin
            state_nxt = STREAM;
            cnt_nxt   = '0;
        end else if (o_valid && i_ready) begin
            cnt_nxt = cnt + 1'b1;
            if (o_last) begin
                state_nxt = IDLE;
            end
        end
    end

    fft_frame_buffer #(
        .p_dataBits (p_dataBits),
        .p_points   (p_points),
        .p_indexBits(p_indexBits)
    ) u_buf (
        .clk    (CLK),
        .rst    (RST),
        .load   (load),
        .din    (frame),
        .rd_idx (rd_idx),
        .rd_word(o_data)
    );

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Randomised self-checking bench for fft_frame_serializer.
// A frame-level model predicts every output on every cycle.
module tb_fft_frame_serializer;

    localparam int DW = 20;

    logic          CLK = 1'b0;
    logic          RST;
    logic          i_frame_valid;
    logic          i_ready;
    logic [DW-1:0] frm [32];
    logic          o_frame_ready;
    logic [DW-1:0] o_data;
    logic [4:0]    o_index;
    logic          o_valid;
    logic          o_last;
    logic          o_busy;
    logic          o_overrun;

    int total = 0;
    int bad   = 0;
    int hs_cnt;

    logic [DW-1:0] m_buf [32];
    int            m_pos;
    bit            m_act;
    bit            m_ovr;

    always #5 CLK = ~CLK;

    fft_frame_serializer dut (
        .CLK(CLK), .RST(RST), .i_frame_valid(i_frame_valid),
        .i_c0(frm[0]),   .i_c1(frm[1]),   .i_c2(frm[2]),   .i_c3(frm[3]),
        .i_c4(frm[4]),   .i_c5(frm[5]),   .i_c6(frm[6]),   .i_c7(frm[7]),
        .i_c8(frm[8]),   .i_c9(frm[9]),   .i_c10(frm[10]), .i_c11(frm[11]),
        .i_c12(frm[12]), .i_c13(frm[13]), .i_c14(frm[14]), .i_c15(frm[15]),
        .i_c16(frm[16]), .i_c17(frm[17]), .i_c18(frm[18]), .i_c19(frm[19]),
        .i_c20(frm[20]), .i_c21(frm[21]), .i_c22(frm[22]), .i_c23(frm[23]),
        .i_c24(frm[24]), .i_c25(frm[25]), .i_c26(frm[26]), .i_c27(frm[27]),
        .i_c28(frm[28]), .i_c29(frm[29]), .i_c30(frm[30]), .i_c31(frm[31]),
        .o_frame_ready(o_frame_ready), .o_data(o_data), .o_index(o_index),
        .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
        .o_busy(o_busy), .o_overrun(o_overrun)
    );

    function automatic int mapi(input int p);
        logic [4:0] b;
        b = p[4:0];
`ifdef FFT_SERIALIZER_BITREV_EN
        return int'(fft_pkg::bitrev5(b));
`else
        return int'(b);
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fill_ramp();
        fft_pkg::cplx_t w;
        for (int k = 0; k < 32; k++) begin
            w.re = 10'(k);
            w.im = 10'(10'h3FF - k);
            frm[k] = w;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 32; k++) frm[k] = DW'($urandom);
    endtask

    // One cycle: drive at negedge, compare against the model, advance the model.
    task automatic step(input bit fv, input bit rdy);
        bit acc;
        i_frame_valid = fv;
        i_ready       = rdy;
        #1;
        check("valid", 32'(o_valid), 32'(m_act));
        check("busy", 32'(o_busy), 32'(m_act));
        check("overrun", 32'(o_overrun), 32'(m_ovr));
        check("last", 32'(o_last), 32'(m_act && m_pos == 31));
        acc = !m_act || (m_pos == 31 && rdy);
        check("frame_ready", 32'(o_frame_ready), 32'(acc));
        if (m_act) begin
            check("index", 32'(o_index), 32'(m_pos));
            check("data", 32'(o_data), 32'(m_buf[mapi(m_pos)]));
        end
        if (m_act && rdy) begin
            hs_cnt++;
            if (m_pos == 31) m_act = 0;
            m_pos = (m_pos + 1) % 32;
        end
        if (fv) begin
            if (acc) begin
                for (int k = 0; k < 32; k++) m_buf[k] = frm[k];
                m_act = 1;
                m_pos = 0;
            end else begin
                m_ovr = 1;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        i_frame_valid = 1'b0;
    endtask

    task automatic run_to(input int pos, input string nm);
        int n;
        n = 0;
        while (m_act && m_pos != pos && n < 100) begin
            step(0, 1);
            n++;
        end
        check({nm, "_reached"}, 32'(m_act && m_pos == pos), 32'd1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (m_act && n < 300) begin
            step(0, 1'($urandom_range(0, 3) != 0));
            n++;
        end
        check({nm, "_drained"}, 32'(m_act), 32'd0);
    endtask

    initial begin
        logic [3:0] pat;
        logic [DW-1:0] pin1, pin5;
        int n;
        pat = 4'b1001;
`ifdef FFT_SERIALIZER_BITREV_EN
        pin1 = {10'd16, 10'h3EF};
        pin5 = {10'd20, 10'h3EB};
`else
        pin1 = {10'd1, 10'h3FE};
        pin5 = {10'd5, 10'h3FA};
`endif
        m_act = 0; m_pos = 0; m_ovr = 0; hs_cnt = 0;
        i_frame_valid = 0; i_ready = 0;
        for (int k = 0; k < 32; k++) frm[k] = '0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_index", 32'(o_index), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_frame_ready", 32'(o_frame_ready), 32'd1);
        RST = 1'b0;

        // Single frame at full rate, with literal pins on two beats.
        fill_ramp();
        step(1, 1);
        hs_cnt = 0;
        n = 0;
        while (m_act && n < 40) begin
            if (m_pos == 1) check("pin_beat1", 32'(o_data), 32'(pin1));
            if (m_pos == 5) check("pin_beat5", 32'(o_data), 32'(pin5));
            step(0, 1);
            n++;
        end
        check("t1_handshakes", 32'(hs_cnt), 32'd32);
        check("t1_cycles", 32'(n), 32'd32);
        step(0, 1);

        // Same frame under a 1,0,0,1 ready pattern.
        step(1, 1);
        hs_cnt = 0;
        n = 0;
        while (m_act && n < 200) begin
            step(0, pat[n % 4]);
            n++;
        end
        check("t2_handshakes", 32'(hs_cnt), 32'd32);

        // Back-to-back frames with the strobe on the last handshake.
        step(1, 1);
        run_to(31, "t3");
        for (int k = 0; k < 32; k++) frm[k] = 20'hABC00 + DW'(k);
        step(1, 1);
        check("b2b_valid", 32'(o_valid), 32'd1);
        check("b2b_index", 32'(o_index), 32'd0);
        check("b2b_data", 32'(o_data), 32'hABC00);
        check("b2b_overrun", 32'(o_overrun), 32'd0);
        drain("t3");

        // Strobe mid-frame is dropped and flags overrun.
        fill_rand();
        step(1, 1);
        run_to(10, "t4");
        fill_rand();
        step(1, 1);
        drain("t4");
        step(0, 1);
        check("ovr_sticky", 32'(o_overrun), 32'd1);

        // Asynchronous reset mid-frame.
        fill_rand();
        step(1, 1);
        run_to(17, "t5");
        #2 RST = 1'b1;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_overrun", 32'(o_overrun), 32'd0);
        check("arst_last", 32'(o_last), 32'd0);
        m_act = 0; m_pos = 0; m_ovr = 0;
        @(negedge CLK);
        RST = 1'b0;
        check("arst_frame_ready", 32'(o_frame_ready), 32'd1);
        fill_rand();
        step(1, 1);
        check("arst_restart_index", 32'(o_index), 32'd0);
        drain("t5");

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            bit fv;
            fv = ($urandom_range(0, 15) == 0) || (!m_act && $urandom_range(0, 1) == 1);
            if (fv) fill_rand();
            step(fv, 1'($urandom_range(0, 3) != 0));
        end
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
